// File: rtl/wt_cache_pkg.sv
// Shared types and width helpers for the write-through cache controller.
package wt_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REFILL,
    WRITE
  } cacheState_e;

  function automatic int tagWidth(input int addrW, input int indexW, input int offsetW);
    return addrW - indexW - offsetW;
  endfunction

  function automatic int wordsPerLine(input int offsetW);
    return 1 << offsetW;
  endfunction

endpackage

// File: rtl/wt_cache_array.sv
// Tag, valid and data storage for the direct-mapped cache: one synchronous
// write port, a combinational read of the indexed line and the hit compare.
module wt_cache_array
  import wt_cache_pkg::*;
#(
  parameter int TAG_W    = 3,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int DATA_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wordWe_i,
  input  logic                vldWe_i,
  input  logic                vldVal_i,
  input  logic [INDEX_W-1:0]  wIndex_i,
  input  logic [OFFSET_W-1:0] wOffset_i,
  input  logic [TAG_W-1:0]    wTag_i,
  input  logic [DATA_W-1:0]   wData_i,
  input  logic [INDEX_W-1:0]  rIndex_i,
  input  logic [OFFSET_W-1:0] rOffset_i,
  input  logic [TAG_W-1:0]    rTag_i,
  output logic [DATA_W-1:0]   rData_o,
  output logic                hit_o
);

  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = LINES * wordsPerLine(OFFSET_W);

  logic [DATA_W-1:0] dataMem [WORDS];
  logic [TAG_W-1:0]  tagMem  [LINES];
  logic [LINES-1:0]  valid_q;

  // Only the valid bits are reset; data and tags keep whatever they held.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (vldWe_i) begin
      valid_q[wIndex_i] <= vldVal_i;
    end
  end

  always_ff @(posedge clk) begin
    if (wordWe_i) begin
      dataMem[{wIndex_i, wOffset_i}] <= wData_i;
    end
    if (vldWe_i && vldVal_i) begin
      tagMem[wIndex_i] <= wTag_i;
    end
  end

  assign rData_o = dataMem[{rIndex_i, rOffset_i}];
  assign hit_o   = valid_q[rIndex_i] && (tagMem[rIndex_i] == rTag_i);

endmodule

// File: rtl/wt_cache_ctrl.sv
// Direct-mapped write-through L1 data cache controller with multi-beat req/ack
// refill. Define CACHE_WRITE_ALLOCATE_EN to refill the line on a write miss.
module wt_cache_ctrl
  import wt_cache_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_ready_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int TAG_W = tagWidth(ADDR_W, INDEX_W, OFFSET_W);
  localparam logic [OFFSET_W-1:0] LAST_BEAT = OFFSET_W'(wordsPerLine(OFFSET_W) - 1);

  cacheState_e         state_q;
  logic [OFFSET_W-1:0] cnt_q;
  logic                memReq_q;
  logic                memWe_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic [DATA_W-1:0]   memWdata_q;

  logic [ADDR_W-1:0]   lookupAddr;
  logic [DATA_W-1:0]   lineWord;
  logic                hit;
  logic                readHit;
  logic                refillBeat;
  logic                lastBeat;

  // Outside IDLE the held request may vanish, so look up the registered address.
  assign lookupAddr = (state_q == IDLE) ? cpu_addr_i : memAddr_q;
  assign refillBeat = (state_q == REFILL) && mem_ack_i;
  assign lastBeat   = refillBeat && (cnt_q == LAST_BEAT);
  assign readHit    = (state_q == IDLE) && cpu_req_i && !cpu_we_i && hit;

  wt_cache_array #(
    .TAG_W   (TAG_W),
    .INDEX_W (INDEX_W),
    .OFFSET_W(OFFSET_W),
    .DATA_W  (DATA_W)
  ) u_array (
    .clk      (clk),
    .rst      (rst),
    .wordWe_i (refillBeat || ((state_q == WRITE) && mem_ack_i && hit)),
    .vldWe_i  (refillBeat),
    .vldVal_i (lastBeat),
    .wIndex_i (memAddr_q[OFFSET_W +: INDEX_W]),
    .wOffset_i(memAddr_q[OFFSET_W-1:0]),
    .wTag_i   (memAddr_q[ADDR_W-1 -: TAG_W]),
    .wData_i  ((state_q == REFILL) ? mem_rdata_i : memWdata_q),
    .rIndex_i (lookupAddr[OFFSET_W +: INDEX_W]),
    .rOffset_i(lookupAddr[OFFSET_W-1:0]),
    .rTag_i   (lookupAddr[ADDR_W-1 -: TAG_W]),
    .rData_o  (lineWord),
    .hit_o    (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req_i && !hit && (!cpu_we_i
`ifdef CACHE_WRITE_ALLOCATE_EN
              || 1'b1
`endif
              )) begin
            state_q   <= REFILL;
            cnt_q     <= '0;
            memReq_q  <= 1'b1;
            memWe_q   <= 1'b0;
            memAddr_q <= {cpu_addr_i[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          end else if (cpu_req_i && cpu_we_i) begin
            state_q    <= WRITE;
            memReq_q   <= 1'b1;
            memWe_q    <= 1'b1;
            memAddr_q  <= cpu_addr_i;
            memWdata_q <= cpu_wdata_i;
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            cnt_q <= cnt_q + OFFSET_W'(1);
            if (cnt_q == LAST_BEAT) begin
              state_q  <= IDLE;
              memReq_q <= 1'b0;
            end else begin
              memAddr_q <= {memAddr_q[ADDR_W-1:OFFSET_W], cnt_q + OFFSET_W'(1)};
            end
          end
        end
        WRITE: begin
          if (mem_ack_i) begin
            state_q  <= IDLE;
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu_ready_o = readHit || ((state_q == WRITE) && mem_ack_i);
  assign cpu_rdata_o = readHit ? lineWord : '0;
  assign mem_req_o   = memReq_q;
  assign mem_we_o    = memWe_q;
  assign mem_addr_o  = memAddr_q;
  assign mem_wdata_o = memWdata_q;

endmodule

// File: tb/tb_wt_cache_ctrl.sv
// Directed self-checking bench for wt_cache_ctrl with a latency-programmable
// req/ack memory model; expectations follow CACHE_WRITE_ALLOCATE_EN when set.
module tb_wt_cache_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpuReq;
  logic        cpuWe;
  logic [9:0]  cpuAddr;
  logic [31:0] cpuWdata;
  logic [31:0] cpuRdata;
  logic        cpuReady;
  logic        memReq;
  logic        memWe;
  logic [9:0]  memAddr;
  logic [31:0] memWdata;
  logic [31:0] memRdata;
  logic        memAck;

  logic        modelAck;
  logic        forceAck;
  int          memLat;
  int          waitCnt;
  logic [31:0] memArr [1024];
  logic [9:0]  rdLog [64];
  int          rdCount;
  int          wrCount;
  logic [9:0]  lastWrAddr;
  logic [31:0] lastWrData;

  int total = 0;
  int bad   = 0;

  wt_cache_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req_i  (cpuReq),
    .cpu_we_i   (cpuWe),
    .cpu_addr_i (cpuAddr),
    .cpu_wdata_i(cpuWdata),
    .cpu_rdata_o(cpuRdata),
    .cpu_ready_o(cpuReady),
    .mem_req_o  (memReq),
    .mem_we_o   (memWe),
    .mem_addr_o (memAddr),
    .mem_wdata_o(memWdata),
    .mem_rdata_i(memRdata),
    .mem_ack_i  (memAck)
  );

  always #5 clk = ~clk;

  assign memRdata = memArr[memAddr];
  assign memAck   = modelAck | forceAck;

  // Ack decided mid-cycle: the (memLat+1)-th cycle of a held request acks.
  always @(negedge clk) begin
    if (!rst || !memReq) begin
      modelAck = 1'b0;
      waitCnt  = 0;
    end else if (waitCnt == memLat) begin
      modelAck = 1'b1;
      waitCnt  = 0;
    end else begin
      modelAck = 1'b0;
      waitCnt  = waitCnt + 1;
    end
  end

  // Completed memory transactions are logged and writes land in memArr.
  always @(posedge clk) begin
    if (rst && memReq && memAck) begin
      if (memWe) begin
        memArr[memAddr] = memWdata;
        lastWrAddr      = memAddr;
        lastWrData      = memWdata;
        wrCount         = wrCount + 1;
      end else begin
        rdLog[rdCount & 63] = memAddr;
        rdCount             = rdCount + 1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One processor access; cycles counts wait states from the request cycle.
  task automatic applyStimulus(input logic we, input logic [9:0] addr, input logic [31:0] wdata,
                               output logic [31:0] rdata, output int cycles);
    @(posedge clk);
    #1;
    cpuReq   = 1'b1;
    cpuWe    = we;
    cpuAddr  = addr;
    cpuWdata = wdata;
    cycles   = 0;
    rdata    = 'x;
    while (1) begin
      @(negedge clk);
      #1;
      if (cpuReady) begin
        rdata = cpuRdata;
        break;
      end
      if (cycles >= 200) begin
        cycles = -1;
        break;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    @(posedge clk);
    #1;
    cpuReq = 1'b0;
    cpuWe  = 1'b0;
  endtask

  task automatic waitReads(input int target);
    int guard;
    guard = 0;
    while (rdCount < target && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("wait_reads", 32'(rdCount >= target), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    int          cyc;
    int          rdBase;
    int          wrBase;

    for (int i = 0; i < 1024; i++) memArr[i] = 32'h5000_0000 | 32'(i);
    for (int i = 0; i < 4; i++) memArr[10'h084 + i] = 32'hA0 + 32'(i);
    rst = 1'b0; cpuReq = 1'b0; cpuWe = 1'b0; cpuAddr = '0; cpuWdata = '0;
    forceAck = 1'b0; memLat = 2; rdCount = 0; wrCount = 0;
    lastWrAddr = '0; lastWrData = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", 32'(memReq), 32'd0);
    checkOutput("rst_mem_we", 32'(memWe), 32'd0);
    checkOutput("rst_mem_addr", 32'(memAddr), 32'd0);
    checkOutput("rst_mem_wdata", memWdata, 32'd0);
    checkOutput("rst_cpu_ready", 32'(cpuReady), 32'd0);
    checkOutput("rst_cpu_rdata", cpuRdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] read miss fill of line 0x084");
    rdBase = rdCount;
    applyStimulus(1'b0, 10'h085, 32'h0, rd, cyc);
    checkOutput("miss_cycles", 32'(cyc), 32'd13);
    checkOutput("miss_rdata", rd, 32'hA1);
    checkOutput("miss_beats", 32'(rdCount - rdBase), 32'd4);
    for (int i = 0; i < 4; i++)
      checkOutput("miss_beat_addr", 32'(rdLog[(rdBase + i) & 63]), 32'h084 + 32'(i));
    applyStimulus(1'b0, 10'h086, 32'h0, rd, cyc);
    checkOutput("hit_cycles", 32'(cyc), 32'd0);
    checkOutput("hit_rdata", rd, 32'hA2);

    $display("[TB] write hit");
    wrBase = wrCount;
    applyStimulus(1'b1, 10'h086, 32'hDEAD, rd, cyc);
    checkOutput("wr_hit_cycles", 32'(cyc), 32'd3);
    checkOutput("wr_hit_count", 32'(wrCount - wrBase), 32'd1);
    checkOutput("wr_hit_addr", 32'(lastWrAddr), 32'h086);
    checkOutput("wr_hit_data", lastWrData, 32'hDEAD);
    applyStimulus(1'b0, 10'h086, 32'h0, rd, cyc);
    checkOutput("wr_hit_reread_cycles", 32'(cyc), 32'd0);
    checkOutput("wr_hit_reread_data", rd, 32'hDEAD);

    $display("[TB] write miss");
    rdBase = rdCount;
    wrBase = wrCount;
    applyStimulus(1'b1, 10'h300, 32'h1234, rd, cyc);
    checkOutput("wr_miss_count", 32'(wrCount - wrBase), 32'd1);
    checkOutput("wr_miss_data", memArr[10'h300], 32'h1234);
`ifdef CACHE_WRITE_ALLOCATE_EN
    checkOutput("wr_miss_cycles", 32'(cyc), 32'd16);
    checkOutput("wr_miss_refill", 32'(rdCount - rdBase), 32'd4);
    applyStimulus(1'b0, 10'h300, 32'h0, rd, cyc);
    checkOutput("wr_miss_read_cycles", 32'(cyc), 32'd0);
`else
    checkOutput("wr_miss_cycles", 32'(cyc), 32'd3);
    checkOutput("wr_miss_refill", 32'(rdCount - rdBase), 32'd0);
    applyStimulus(1'b0, 10'h300, 32'h0, rd, cyc);
    checkOutput("wr_miss_read_cycles", 32'(cyc), 32'd13);
`endif
    checkOutput("wr_miss_read_data", rd, 32'h1234);

    $display("[TB] conflict eviction");
    applyStimulus(1'b0, 10'h105, 32'h0, rd, cyc);
    checkOutput("conflict_cycles", 32'(cyc), 32'd13);
    checkOutput("conflict_rdata", rd, 32'h5000_0105);
    applyStimulus(1'b0, 10'h085, 32'h0, rd, cyc);
    checkOutput("evicted_cycles", 32'(cyc), 32'd13);
    checkOutput("evicted_rdata", rd, 32'hA1);

    $display("[TB] zero-latency memory");
    memLat = 0;
    applyStimulus(1'b0, 10'h2E0, 32'h0, rd, cyc);
    checkOutput("l0_miss_cycles", 32'(cyc), 32'd5);
    checkOutput("l0_miss_rdata", rd, 32'h5000_02E0);
    applyStimulus(1'b1, 10'h2E1, 32'h55, rd, cyc);
    checkOutput("l0_write_cycles", 32'(cyc), 32'd1);
    applyStimulus(1'b0, 10'h2E1, 32'h0, rd, cyc);
    checkOutput("l0_reread_cycles", 32'(cyc), 32'd0);
    checkOutput("l0_reread_rdata", rd, 32'h55);
    memLat = 2;

    $display("[TB] reset during third refill beat");
    rdBase = rdCount;
    @(posedge clk);
    #1;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 10'h0A9;
    waitReads(rdBase + 2);
    @(negedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_mem_req", 32'(memReq), 32'd0);
    checkOutput("async_rst_ready", 32'(cpuReady), 32'd0);
    cpuReq = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    rdBase = rdCount;
    applyStimulus(1'b0, 10'h0A9, 32'h0, rd, cyc);
    checkOutput("post_rst_cycles", 32'(cyc), 32'd13);
    checkOutput("post_rst_beats", 32'(rdCount - rdBase), 32'd4);
    checkOutput("post_rst_rdata", rd, 32'h5000_00A9);
    applyStimulus(1'b0, 10'h085, 32'h0, rd, cyc);
    checkOutput("post_rst_invalid", 32'(cyc), 32'd13);

    $display("[TB] request dropped mid-refill");
    rdBase = rdCount;
    @(posedge clk);
    #1;
    cpuReq = 1'b1; cpuWe = 1'b0; cpuAddr = 10'h1C2;
    waitReads(rdBase + 1);
    cpuReq = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("drop_beats", 32'(rdCount - rdBase), 32'd4);
    checkOutput("drop_mem_req", 32'(memReq), 32'd0);
    applyStimulus(1'b0, 10'h1C2, 32'h0, rd, cyc);
    checkOutput("drop_installed_cycles", 32'(cyc), 32'd0);
    checkOutput("drop_installed_rdata", rd, 32'h5000_01C2);

    $display("[TB] spurious ack in idle");
    rdBase = rdCount;
    wrBase = wrCount;
    @(negedge clk);
    forceAck = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("spurious_mem_req", 32'(memReq), 32'd0);
    checkOutput("spurious_ready", 32'(cpuReady), 32'd0);
    @(negedge clk);
    forceAck = 1'b0;
    checkOutput("spurious_reads", 32'(rdCount - rdBase), 32'd0);
    checkOutput("spurious_writes", 32'(wrCount - wrBase), 32'd0);
    applyStimulus(1'b0, 10'h1C2, 32'h0, rd, cyc);
    checkOutput("spurious_hit_cycles", 32'(cyc), 32'd0);
    checkOutput("spurious_hit_rdata", rd, 32'h5000_01C2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
